// File: rtl/alu_pipe_param_if.sv
// rtl/alu_pipe_param_if.sv - operand/command/result bundle for alu_pipe_param (top header names ALU_MUL_EN)
interface alu_pipe_param_if #(
    parameter int WIDTH = 8
);
    logic               CE;
    logic               MODE;
    logic [3:0]         CMD;
    logic [1:0]         INP_VALID;
    logic               CIN;
    logic [WIDTH-1:0]   OPA;
    logic [WIDTH-1:0]   OPB;
    logic [2*WIDTH-1:0] RES;
    logic               COUT;
    logic               OFLOW;
    logic               G;
    logic               E;
    logic               L;
    logic               ERR;
    logic               OUT_VALID;
    logic               BUSY;

    modport master (
        output CE, MODE, CMD, INP_VALID, CIN, OPA, OPB,
        input  RES, COUT, OFLOW, G, E, L, ERR, OUT_VALID, BUSY
    );

    modport slave (
        input  CE, MODE, CMD, INP_VALID, CIN, OPA, OPB,
        output RES, COUT, OFLOW, G, E, L, ERR, OUT_VALID, BUSY
    );
endinterface

// File: rtl/alu_pipe_param.sv
// rtl/alu_pipe_param.sv - handshaked parametrised ALU with operand collection and timeout; ALU_MUL_EN builds the multiplier
module alu_pipe_param #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    alu_pipe_param_if.slave   bus
);
    localparam int W  = WIDTH;
    localparam int LG = $clog2(WIDTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [W:0]    ONE1    = 1;

    typedef enum logic [1:0] {IDLE, WAIT_OP, MUL1, MUL2} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [W-1:0]      opa_q, opb_q;
    logic [3:0]        cmd_q;
    logic              mode_q, cin_q, have_a_q;

    logic [2*W-1:0]    res_q;
    logic              cout_q, oflow_q, g_q, e_q, l_q, err_q, valid_q;

    // Operands/controls seen by the execute logic: live inputs in IDLE,
    // latched controls plus the newly arriving operand in WAIT_OP.
    logic [W-1:0]      a_sel, b_sel;
    logic [3:0]        cmd_sel;
    logic              mode_sel, cin_sel;

    logic              need_a, need_b, ready, arrive;
    logic              lat_in, fire, fire_to, cnt_clr, cnt_inc;

    logic [2*W-1:0]    c_res;
    logic              c_cout, c_oflow, c_g, c_e, c_l, c_err;

    wire               v_a = bus.INP_VALID[0];
    wire               v_b = bus.INP_VALID[1];

`ifdef ALU_MUL_EN
    localparam logic [2*W-1:0] ONE2 = 1;
    logic              is_mul, fire_mul;
    logic [2*W-1:0]    pa, pb, prod_d, prod_q;
`endif

    // Select the operand/control source depending on whether we are collecting
    always_comb begin
        cmd_sel  = bus.CMD;
        mode_sel = bus.MODE;
        cin_sel  = bus.CIN;
        a_sel    = bus.OPA;
        b_sel    = bus.OPB;
        if (state_q == WAIT_OP) begin
            cmd_sel  = cmd_q;
            mode_sel = mode_q;
            cin_sel  = cin_q;
            a_sel    = have_a_q ? opa_q : bus.OPA;
            b_sel    = have_a_q ? bus.OPB : opb_q;
        end
    end

    // Which operands the selected command consumes
    always_comb begin
        need_a = 1'b1;
        need_b = 1'b1;
        if (mode_sel) begin
            case (cmd_sel)
                4'd4, 4'd5: need_b = 1'b0;
                4'd6, 4'd7: need_a = 1'b0;
                default: ;
            endcase
        end else begin
            case (cmd_sel)
                4'd6, 4'd8, 4'd9:   need_b = 1'b0;
                4'd7, 4'd10, 4'd11: need_a = 1'b0;
                default: ;
            endcase
        end
    end

    assign ready  = (!need_a || v_a) && (!need_b || v_b);
    assign arrive = have_a_q ? v_b : v_a;

`ifdef ALU_MUL_EN
    assign is_mul = mode_sel && ((cmd_sel == 4'd9) || (cmd_sel == 4'd10));
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST)
            state_q <= IDLE;
        else if (bus.CE)
            state_q <= state_d;
    end

    // Next-state and control strobes
    always_comb begin
        state_d = state_q;
        lat_in  = 1'b0;
        fire    = 1'b0;
        fire_to = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
`ifdef ALU_MUL_EN
        fire_mul = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ready) begin
                    lat_in = 1'b1;
                    fire   = 1'b1;
`ifdef ALU_MUL_EN
                    if (is_mul) begin
                        fire    = 1'b0;
                        state_d = MUL1;
                    end
`endif
                end else if (need_a && need_b && (v_a ^ v_b)) begin
                    lat_in  = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (arrive) begin
                    lat_in  = 1'b1;
                    fire    = 1'b1;
                    state_d = IDLE;
`ifdef ALU_MUL_EN
                    if (is_mul) begin
                        fire    = 1'b0;
                        state_d = MUL1;
                    end
`endif
                end else if (cnt_q == TO_LAST) begin
                    fire_to = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
`ifdef ALU_MUL_EN
            MUL1: state_d = MUL2;
            MUL2: begin
                fire_mul = 1'b1;
                state_d  = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Single-cycle execute of every non-multiply command
    always_comb begin
        logic [W:0]     ax, bx, ar;
        logic [2*W-1:0] rot;
        ax      = {1'b0, a_sel};
        bx      = {1'b0, b_sel};
        ar      = '0;
        rot     = '0;
        c_res   = '0;
        c_cout  = 1'b0;
        c_oflow = 1'b0;
        c_g     = 1'b0;
        c_e     = 1'b0;
        c_l     = 1'b0;
        c_err   = 1'b0;
        if (mode_sel) begin
            case (cmd_sel)
                4'd0: begin ar = ax + bx;                       c_cout  = ar[W]; end
                4'd1: begin ar = ax - bx;                       c_oflow = ar[W]; end
                4'd2: begin ar = ax + bx + {{W{1'b0}}, cin_sel}; c_cout  = ar[W]; end
                4'd3: begin ar = ax - bx - {{W{1'b0}}, cin_sel}; c_oflow = ar[W]; end
                4'd4: begin ar = ax + ONE1;                     c_cout  = ar[W]; end
                4'd5: begin ar = ax - ONE1;                     c_oflow = ar[W]; end
                4'd6: begin ar = bx + ONE1;                     c_cout  = ar[W]; end
                4'd7: begin ar = bx - ONE1;                     c_oflow = ar[W]; end
                4'd8: begin
                    c_g = (a_sel > b_sel);
                    c_e = (a_sel == b_sel);
                    c_l = (a_sel < b_sel);
                end
                default: c_err = 1'b1;
            endcase
            c_res = {{W{1'b0}}, ar[W-1:0]};
        end else begin
            case (cmd_sel)
                4'd0:  c_res = {{W{1'b0}}, a_sel & b_sel};
                4'd1:  c_res = {{W{1'b0}}, ~(a_sel & b_sel)};
                4'd2:  c_res = {{W{1'b0}}, a_sel | b_sel};
                4'd3:  c_res = {{W{1'b0}}, ~(a_sel | b_sel)};
                4'd4:  c_res = {{W{1'b0}}, a_sel ^ b_sel};
                4'd5:  c_res = {{W{1'b0}}, ~(a_sel ^ b_sel)};
                4'd6:  c_res = {{W{1'b0}}, ~a_sel};
                4'd7:  c_res = {{W{1'b0}}, ~b_sel};
                4'd8:  c_res = {{W{1'b0}}, 1'b0, a_sel[W-1:1]};
                4'd9:  c_res = {{W{1'b0}}, a_sel[W-2:0], 1'b0};
                4'd10: c_res = {{W{1'b0}}, 1'b0, b_sel[W-1:1]};
                4'd11: c_res = {{W{1'b0}}, b_sel[W-2:0], 1'b0};
                4'd12, 4'd13: begin
                    // Rotate amounts beyond WIDTH-1 are rejected, not wrapped
                    if (|b_sel[W-1:LG]) begin
                        c_err = 1'b1;
                    end else if (cmd_sel == 4'd12) begin
                        rot   = {a_sel, a_sel} << b_sel[LG-1:0];
                        c_res = {{W{1'b0}}, rot[2*W-1:W]};
                    end else begin
                        rot   = {a_sel, a_sel} >> b_sel[LG-1:0];
                        c_res = {{W{1'b0}}, rot[W-1:0]};
                    end
                end
                default: c_err = 1'b1;
            endcase
        end
    end

`ifdef ALU_MUL_EN
    // Multiplier operand shaping from the latched operands (used in MUL1)
    always_comb begin
        if (cmd_q == 4'd9) begin
            pa = {{W{1'b0}}, opa_q} + ONE2;
            pb = {{W{1'b0}}, opb_q} + ONE2;
        end else begin
            pa = {{W{1'b0}}, opa_q[W-2:0], 1'b0};
            pb = {{W{1'b0}}, opb_q};
        end
        prod_d = pa * pb;
    end
`endif

    // Operand latches, timeout counter and registered result outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            cmd_q    <= '0;
            mode_q   <= 1'b0;
            cin_q    <= 1'b0;
            have_a_q <= 1'b0;
            res_q    <= '0;
            cout_q   <= 1'b0;
            oflow_q  <= 1'b0;
            g_q      <= 1'b0;
            e_q      <= 1'b0;
            l_q      <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
`ifdef ALU_MUL_EN
            prod_q   <= '0;
`endif
        end else if (bus.CE) begin
            valid_q <= 1'b0;
            if (cnt_clr) begin
                cnt_q    <= '0;
                have_a_q <= v_a;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (lat_in) begin
                opa_q  <= a_sel;
                opb_q  <= b_sel;
                cmd_q  <= cmd_sel;
                mode_q <= mode_sel;
                cin_q  <= cin_sel;
            end
            if (fire) begin
                res_q   <= c_res;
                cout_q  <= c_cout;
                oflow_q <= c_oflow;
                g_q     <= c_g;
                e_q     <= c_e;
                l_q     <= c_l;
                err_q   <= c_err;
                valid_q <= 1'b1;
            end
            if (fire_to) begin
                res_q   <= '0;
                cout_q  <= 1'b0;
                oflow_q <= 1'b0;
                g_q     <= 1'b0;
                e_q     <= 1'b0;
                l_q     <= 1'b0;
                err_q   <= 1'b1;
                valid_q <= 1'b1;
            end
`ifdef ALU_MUL_EN
            if (state_q == MUL1)
                prod_q <= prod_d;
            if (fire_mul) begin
                res_q   <= prod_q;
                cout_q  <= 1'b0;
                oflow_q <= 1'b0;
                g_q     <= 1'b0;
                e_q     <= 1'b0;
                l_q     <= 1'b0;
                err_q   <= 1'b0;
                valid_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.RES       = res_q;
    assign bus.COUT      = cout_q;
    assign bus.OFLOW     = oflow_q;
    assign bus.G         = g_q;
    assign bus.E         = e_q;
    assign bus.L         = l_q;
    assign bus.ERR       = err_q;
    assign bus.OUT_VALID = valid_q;
`ifdef ALU_MUL_EN
    assign bus.BUSY      = (state_q == WAIT_OP) || (state_q == MUL1) || (state_q == MUL2);
`else
    assign bus.BUSY      = (state_q == WAIT_OP);
`endif
endmodule

// File: tb/tb_alu_pipe_param.sv
// tb/tb_alu_pipe_param.sv - directed self-checking bench for alu_pipe_param
module tb_alu_pipe_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_pipe_param_if #(.WIDTH(8)) bus ();

    alu_pipe_param #(.WIDTH(8), .TIMEOUT(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mode, input logic [3:0] cmd, input logic [1:0] iv,
                         input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus.MODE      = mode;
        bus.CMD       = cmd;
        bus.INP_VALID = iv;
        bus.OPA       = a;
        bus.OPB       = b;
        bus.CIN       = cin;
    endtask

    initial begin
        bus.CE = 1'b1;
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        steps(2);
        rst = 1'b0;
        chk("rst_res", bus.RES, 32'h0);
        chk("rst_valid", bus.OUT_VALID, 0);
        chk("rst_err", bus.ERR, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_cout", bus.COUT, 0);

        // ADD with carry out
        drive(1'b1, 4'd0, 2'b11, 8'hFF, 8'h01, 1'b0);
        step();
        bus.INP_VALID = 2'b00;
        chk("add_res", bus.RES, 32'h0000);
        chk("add_cout", bus.COUT, 1);
        chk("add_valid", bus.OUT_VALID, 1);
        chk("add_oflow", bus.OFLOW, 0);
        step();
        chk("add_pulse", bus.OUT_VALID, 0);
        chk("add_hold", bus.COUT, 1);

`ifdef ALU_MUL_EN
        // MUL_INC: (3+1)*(4+1) = 20
        drive(1'b1, 4'd9, 2'b11, 8'h03, 8'h04, 1'b0);
        step();
        bus.INP_VALID = 2'b00;
        chk("mul_busy1", bus.BUSY, 1);
        chk("mul_nv1", bus.OUT_VALID, 0);
        step();
        chk("mul_busy2", bus.BUSY, 1);
        step();
        chk("mul_busy3", bus.BUSY, 0);
        chk("mul_valid", bus.OUT_VALID, 1);
        chk("mul_res", bus.RES, 32'h0014);
        // MUL_SHL: 0xFE * 0xFF = 0xFD02
        drive(1'b1, 4'd10, 2'b11, 8'h7F, 8'hFF, 1'b0);
        step();
        bus.INP_VALID = 2'b00;
        steps(2);
        chk("mulshl_res", bus.RES, 32'hFD02);
        chk("mulshl_valid", bus.OUT_VALID, 1);
`else
        drive(1'b1, 4'd9, 2'b11, 8'h03, 8'h04, 1'b0);
        step();
        bus.INP_VALID = 2'b00;
        chk("nomul_err", bus.ERR, 1);
        chk("nomul_valid", bus.OUT_VALID, 1);
        chk("nomul_res", bus.RES, 32'h0);
        chk("nomul_busy", bus.BUSY, 0);
`endif

        // Split operands: A first, B after 4 idle cycles; CMD changes are ignored
        drive(1'b1, 4'd0, 2'b01, 8'h05, 8'hEE, 1'b0);
        step();
        chk("split_busy", bus.BUSY, 1);
        chk("split_nv", bus.OUT_VALID, 0);
        drive(1'b1, 4'd1, 2'b00, 8'hAA, 8'hEE, 1'b0);
        steps(4);
        drive(1'b1, 4'd1, 2'b10, 8'hAA, 8'h07, 1'b0);
        step();
        bus.INP_VALID = 2'b00;
        chk("split_res", bus.RES, 32'h000C);
        chk("split_valid", bus.OUT_VALID, 1);
        chk("split_busy_end", bus.BUSY, 0);

        // Timeout after 16 cycles without OPB
        drive(1'b1, 4'd0, 2'b01, 8'h11, 8'h00, 1'b0);
        step();
        bus.INP_VALID = 2'b00;
        steps(15);
        chk("to_early_nv", bus.OUT_VALID, 0);
        chk("to_early_busy", bus.BUSY, 1);
        step();
        chk("to_err", bus.ERR, 1);
        chk("to_valid", bus.OUT_VALID, 1);
        chk("to_res", bus.RES, 32'h0);
        chk("to_busy", bus.BUSY, 0);

        // Rotates and rotate range error
        drive(1'b0, 4'd12, 2'b11, 8'h81, 8'h01, 1'b0);
        step();
        chk("rol_res", bus.RES, 32'h0003);
        chk("rol_err", bus.ERR, 0);
        drive(1'b0, 4'd12, 2'b11, 8'h81, 8'h10, 1'b0);
        step();
        chk("rol_range_err", bus.ERR, 1);
        chk("rol_range_res", bus.RES, 32'h0);
        drive(1'b0, 4'd13, 2'b11, 8'h81, 8'h01, 1'b0);
        step();
        chk("ror_res", bus.RES, 32'h00C0);

        // Arithmetic borrow, compare, single-operand, illegal, logic
        drive(1'b1, 4'd1, 2'b11, 8'h03, 8'h05, 1'b0);
        step();
        chk("sub_res", bus.RES, 32'h00FE);
        chk("sub_oflow", bus.OFLOW, 1);
        drive(1'b1, 4'd3, 2'b11, 8'h10, 8'h05, 1'b1);
        step();
        chk("subcin_res", bus.RES, 32'h000A);
        chk("subcin_oflow", bus.OFLOW, 0);
        drive(1'b1, 4'd8, 2'b11, 8'h05, 8'h05, 1'b0);
        step();
        chk("cmp_e", bus.E, 1);
        chk("cmp_g", bus.G, 0);
        chk("cmp_res", bus.RES, 32'h0);
        drive(1'b1, 4'd5, 2'b01, 8'h00, 8'h00, 1'b0);
        step();
        chk("deca_res", bus.RES, 32'h00FF);
        chk("deca_oflow", bus.OFLOW, 1);
        chk("deca_valid", bus.OUT_VALID, 1);
        drive(1'b0, 4'd15, 2'b11, 8'h12, 8'h34, 1'b0);
        step();
        chk("illegal_err", bus.ERR, 1);
        chk("illegal_res", bus.RES, 32'h0);
        drive(1'b0, 4'd1, 2'b11, 8'hF0, 8'h3C, 1'b0);
        step();
        chk("nand_res", bus.RES, 32'h00CF);
        chk("nand_err", bus.ERR, 0);
        bus.INP_VALID = 2'b00;

        // Reset in the middle of WAIT_OP
        drive(1'b1, 4'd0, 2'b01, 8'h09, 8'h00, 1'b0);
        step();
        bus.INP_VALID = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_res", bus.RES, 32'h0);
        chk("rstw_busy", bus.BUSY, 0);
        chk("rstw_valid", bus.OUT_VALID, 0);

`ifdef ALU_MUL_EN
        // Reset during MUL1 aborts the multiply
        drive(1'b1, 4'd9, 2'b11, 8'h03, 8'h04, 1'b0);
        step();
        bus.INP_VALID = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(3);
        chk("rstm_valid", bus.OUT_VALID, 0);
        chk("rstm_res", bus.RES, 32'h0);
        chk("rstm_busy", bus.BUSY, 0);
`endif

        // CE low for 20 cycles mid-WAIT_OP: no timeout progress
        drive(1'b1, 4'd0, 2'b01, 8'h02, 8'h00, 1'b0);
        step();
        bus.INP_VALID = 2'b00;
        steps(5);
        bus.CE = 1'b0;
        steps(20);
        chk("ce_busy", bus.BUSY, 1);
        bus.CE = 1'b1;
        steps(9);
        chk("ce_no_to", bus.OUT_VALID, 0);
        chk("ce_busy2", bus.BUSY, 1);
        drive(1'b1, 4'd0, 2'b10, 8'h00, 8'h03, 1'b0);
        step();
        bus.INP_VALID = 2'b00;
        chk("ce_res", bus.RES, 32'h0005);
        chk("ce_valid", bus.OUT_VALID, 1);
        chk("ce_err", bus.ERR, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
